// File: rtl/adc_init_pkg.sv
// Shared types and the power-up register table for the audio ADC init sequencer.
package adc_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } seq_state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } init_entry_t;

  localparam int DEF_NUM_ENTRIES = 6;

  // Written in this order at power-up.
  localparam init_entry_t INIT_TABLE [DEF_NUM_ENTRIES] = '{
    '{8'h29, 8'h00},
    '{8'h26, 8'h11},
    '{8'h04, 8'h00},  // slave mode
    '{8'h0C, 8'h00},  // ADC clk div
    '{8'h0D, 8'h01},  // ADC num select
    '{8'h00, 8'h02}   // ADC enable
  };

  // Bits needed to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_init_rom.sv
// Combinational lookup of the init table; indices past the table read as 0x00/0x00.
module adc_init_rom
  import adc_init_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] reg_addr,
  output logic [7:0] data
);

  always_comb begin
    // NOTE: defaults come first so no path through the block leaves an output unassigned (no latch).
    reg_addr = 8'h00;
    data     = 8'h00;
    for (int i = 0; i < DEF_NUM_ENTRIES; i++) begin
      if (idx == 4'(i)) begin
        reg_addr = INIT_TABLE[i].reg_addr;
        data     = INIT_TABLE[i].data;
      end
    end
  end

endmodule

// File: rtl/adc_i2c_init_sequencer.sv
// Walks the ADC init table, issuing one I2C byte write per entry with retry,
// busy timeout and an idle gap between transfers.
module adc_i2c_init_sequencer
  import adc_init_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h10,
  parameter int         NUM_ENTRIES  = DEF_NUM_ENTRIES,
  parameter int         MAX_RETRY    = 3,
  parameter int         BUSY_TIMEOUT = 2_000_000,
  parameter int         GAP_CYCLES   = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  output logic       i2c_start,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  input  logic       i2c_ack_error,
  output logic       seq_busy,
  output logic       done,
  output logic       error,
  output logic [3:0] fail_index
);

  localparam int RW = cnt_width(MAX_RETRY);
  localparam int TW = cnt_width(BUSY_TIMEOUT);
  localparam int GW = cnt_width(GAP_CYCLES);

  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);
  localparam logic [3:0]    LAST_IDX  = 4'(NUM_ENTRIES - 1);

  seq_state_t    state, state_n;
  logic [3:0]    idx, idx_n;
  logic [RW-1:0] retry, retry_n;
  logic [TW-1:0] tmo, tmo_n, tmo_inc;
  logic [GW-1:0] gap, gap_n, gap_inc;
  logic          tmo_fail, tmo_fail_n;
  logic          tmo_expired;
  logic          start_n, seq_busy_n, done_n, error_n;
  logic [7:0]    reg_addr_n, data_n, rom_reg_addr, rom_data;
  logic [3:0]    fail_index_n;

  adc_init_rom u_rom (
    .idx      (idx),
    .reg_addr (rom_reg_addr),
    .data     (rom_data)
  );

  assign i2c_addr    = DEV_ADDR;
  assign tmo_inc     = tmo + TW'(1);
  assign gap_inc     = gap + GW'(1);
  assign tmo_expired = (tmo_inc == TMO_LAST);

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    retry_n      = retry;
    tmo_n        = tmo;
    gap_n        = gap;
    tmo_fail_n   = tmo_fail;
    start_n      = 1'b0;
    seq_busy_n   = seq_busy;
    done_n       = done;
    error_n      = error;
    fail_index_n = fail_index;
    reg_addr_n   = i2c_reg_addr;
    data_n       = i2c_data;

    unique case (state)
      ST_IDLE: if (go) begin
        done_n       = 1'b0;
        error_n      = 1'b0;
        fail_index_n = 4'd0;
        idx_n        = 4'd0;
        retry_n      = '0;
        state_n      = ST_LOAD;
      end
      ST_LOAD: begin
        reg_addr_n = rom_reg_addr;
        data_n     = rom_data;
        seq_busy_n = 1'b1;
        tmo_n      = '0;
        tmo_fail_n = 1'b0;
        start_n    = 1'b1;
        state_n    = ST_ISSUE;
      end
      // Start is held because the master only samples it on its own clock enable.
      // The timeout wins over a simultaneous busy so the counter never passes its limit.
      ST_ISSUE: begin
        tmo_n = tmo_inc;
        if (tmo_expired) begin
          tmo_fail_n = 1'b1;
          state_n    = ST_CHECK;
        end else if (i2c_busy) begin
          state_n = ST_WAIT;
        end else begin
          start_n = 1'b1;
        end
      end
      ST_WAIT: begin
        tmo_n = tmo_inc;
        if (tmo_expired) begin
          tmo_fail_n = 1'b1;
          state_n    = ST_CHECK;
        end else if (!i2c_busy) begin
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        gap_n = '0;
        if (!tmo_fail && !i2c_ack_error) begin
          idx_n   = idx + 4'd1;
          retry_n = '0;
          state_n = (idx == LAST_IDX) ? ST_DONE : ST_GAP;
        end else if (retry < RETRY_MAX) begin
          retry_n = retry + RW'(1);
          state_n = ST_GAP;
        end else begin
          state_n = ST_FAIL;
        end
      end
      ST_GAP: begin
        gap_n = gap_inc;
        if (gap_inc == GAP_LAST) state_n = ST_LOAD;
      end
      ST_DONE: begin
        done_n     = 1'b1;
        seq_busy_n = 1'b0;
        state_n    = ST_IDLE;
      end
      ST_FAIL: begin
        error_n      = 1'b1;
        fail_index_n = idx;
        seq_busy_n   = 1'b0;
        state_n      = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples its pre-edge inputs.
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= 4'd0;
      retry        <= '0;
      tmo          <= '0;
      gap          <= '0;
      tmo_fail     <= 1'b0;
      i2c_start    <= 1'b0;
      i2c_reg_addr <= 8'h00;
      i2c_data     <= 8'h00;
      seq_busy     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      fail_index   <= 4'd0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      retry        <= retry_n;
      tmo          <= tmo_n;
      gap          <= gap_n;
      tmo_fail     <= tmo_fail_n;
      i2c_start    <= start_n;
      i2c_reg_addr <= reg_addr_n;
      i2c_data     <= data_n;
      seq_busy     <= seq_busy_n;
      done         <= done_n;
      error        <= error_n;
      fail_index   <= fail_index_n;
    end
  end

endmodule

// File: tb/tb_adc_i2c_init_sequencer.sv
// Bench for the ADC init sequencer: a behavioural I2C master plus an
// attempt-level model of which writes should appear and how each run ends.
module tb_adc_i2c_init_sequencer;

  localparam int TMO     = 200;
  localparam int GAP     = 4;
  localparam int RETRIES = 3;
  localparam int N       = 6;

  logic       clk = 1'b0;
  logic       reset, go;
  logic       i2c_start, i2c_busy, i2c_ack_error;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_reg_addr, i2c_data;
  logic       seq_busy, done, error;
  logic [3:0] fail_index;

  adc_i2c_init_sequencer #(
    .DEV_ADDR     (7'h10),
    .NUM_ENTRIES  (N),
    .MAX_RETRY    (RETRIES),
    .BUSY_TIMEOUT (TMO),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .i2c_start     (i2c_start),
    .i2c_addr      (i2c_addr),
    .i2c_reg_addr  (i2c_reg_addr),
    .i2c_data      (i2c_data),
    .i2c_busy      (i2c_busy),
    .i2c_ack_error (i2c_ack_error),
    .seq_busy      (seq_busy),
    .done          (done),
    .error         (error),
    .fail_index    (fail_index)
  );

  always #5 clk = ~clk;

  logic [15:0] ref_table [N] = '{16'h2900, 16'h2611, 16'h0400, 16'h0C00, 16'h0D01, 16'h0002};

  // Scenario knobs, written by the test sequence only.
  int nack_plan [N];
  int hang_ent, fixed_delay, fixed_len;

  // Written by the master model only.
  int          nack_cnt [N];
  int          m_phase, cur_ent, stab_err;
  logic [15:0] obs_q[$];
  int          hi_q[$], exp_hi_q[$];

  // Written by the test sequence only.
  logic [15:0] exp_q[$];
  logic        exp_done, exp_err;
  logic [3:0]  exp_fi;
  int          total = 0, bad = 0;

  // Master model acts 2 time units after each rising edge, away from DUT sampling.
  initial begin : master_model
    int   wait_cnt, hold_cnt, delay, len, hi_cnt, ent;
    logic nack_now, hang;
    logic [15:0] cur_pair;
    i2c_busy = 1'b0; i2c_ack_error = 1'b0; m_phase = 0; cur_ent = -1; stab_err = 0;
    nack_now = 1'b0; hang = 1'b0; cur_pair = '0;
    wait_cnt = 0; hold_cnt = 0; delay = 1; len = 1; hi_cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        i2c_busy = 1'b0; i2c_ack_error = 1'b0; m_phase = 0;
      end else begin
        if (go && !seq_busy) begin
          obs_q.delete(); hi_q.delete(); exp_hi_q.delete(); stab_err = 0;
          foreach (nack_cnt[i]) nack_cnt[i] = 0;
        end
        if (m_phase != 0 && {i2c_reg_addr, i2c_data} !== cur_pair) stab_err++;
        case (m_phase)
          0: if (i2c_start) begin
            cur_pair = {i2c_reg_addr, i2c_data};
            ent = -1;
            foreach (ref_table[i]) if (ref_table[i] == cur_pair) ent = i;
            cur_ent  = ent;
            hang     = (ent >= 0) && (ent == hang_ent);
            nack_now = (ent >= 0) && (nack_cnt[ent] < nack_plan[ent]);
            if (nack_now) nack_cnt[ent]++;
            delay = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 10));
            len   = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 30));
            obs_q.push_back(cur_pair);
            exp_hi_q.push_back(hang ? TMO : delay + 1);
            hi_cnt = 1; wait_cnt = 0; m_phase = 1;
          end
          1: begin
            if (!i2c_start) begin
              hi_q.push_back(hi_cnt); m_phase = 0;
            end else begin
              hi_cnt++; wait_cnt++;
              if (!hang && wait_cnt == delay) begin
                i2c_busy = 1'b1; hold_cnt = 0; m_phase = 2;
              end
            end
          end
          default: begin
            if (i2c_start) hi_cnt++;
            hold_cnt++;
            if (hold_cnt == len) begin
              i2c_busy = 1'b0; i2c_ack_error = nack_now;
              hi_q.push_back(hi_cnt); m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Expected write list: each entry retried until it succeeds or runs out of attempts.
  function automatic void build_expect();
    int fails, tries;
    exp_q.delete(); exp_done = 1'b1; exp_err = 1'b0; exp_fi = 4'd0;
    for (int e = 0; e < N; e++) begin
      fails = (e == hang_ent) ? RETRIES + 1 : nack_plan[e];
      tries = (fails > RETRIES) ? RETRIES + 1 : fails + 1;
      repeat (tries) exp_q.push_back(ref_table[e]);
      if (fails > RETRIES) begin
        exp_done = 1'b0; exp_err = 1'b1; exp_fi = 4'(e);
        break;
      end
    end
  endfunction

  function automatic int pair_diffs();
    int d = 0;
    if (obs_q.size() != exp_q.size()) d++;
    foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic int hi_diffs();
    int d = 0;
    if (hi_q.size() != exp_hi_q.size()) d++;
    foreach (exp_hi_q[i]) if (i >= hi_q.size() || hi_q[i] != exp_hi_q[i]) d++;
    return d;
  endfunction

  function automatic void set_scenario(input int nack_ent, input int nacks, input int hang, input int dly, input int len);
    foreach (nack_plan[i]) nack_plan[i] = (i == nack_ent) ? nacks : 0;
    hang_ent = hang; fixed_delay = dly; fixed_len = len;
  endfunction

  // Pulse go, optionally poke go again while entry poke_ent is in flight, wait for the end.
  task automatic run_sequence(input int poke_ent);
    bit finished = 0, poked = 0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (!poked && poke_ent >= 0 && seq_busy && m_phase != 0 && cur_ent == poke_ent) begin
        go = 1'b1; @(negedge clk); go = 1'b0; poked = 1;
      end
      if (done || error) begin
        finished = 1;
        break;
      end
    end
    repeat (40) @(negedge clk);
    total++;
    if (!finished) begin
      bad++; $display("FAIL seq_end: no done/error within 20000 cycles, want one of them");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({i2c_start, i2c_reg_addr, i2c_data, seq_busy, done, error, fail_index} !== 24'h0) begin
      bad++; $display("FAIL reset_outputs: got %h, want 000000",
                      {i2c_start, i2c_reg_addr, i2c_data, seq_busy, done, error, fail_index});
    end
    total++;
    if (i2c_addr !== 7'h10) begin
      bad++; $display("FAIL dev_addr: got %h, want 10", i2c_addr);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (i2c_start !== 1'b0 || seq_busy !== 1'b0) begin
      bad++; $display("FAIL idle_no_go: start=%b seq_busy=%b, want 0 0", i2c_start, seq_busy);
    end
  endtask

  task automatic test_happy_path();
    set_scenario(-1, 0, -1, 0, 20);
    build_expect();
    run_sequence(-1);
    total++;
    if (pair_diffs() != 0) begin
      bad++; $display("FAIL happy_writes: got %0d writes (%0d diffs), want %0d", obs_q.size(), pair_diffs(), exp_q.size());
    end
    total++;
    if (hi_diffs() != 0) begin
      bad++; $display("FAIL happy_start_len: %0d start-length diffs, want 0", hi_diffs());
    end
    total++;
    if ({done, error, seq_busy} !== 3'b100) begin
      bad++; $display("FAIL happy_status: done/error/seq_busy=%b, want 100", {done, error, seq_busy});
    end
    total++;
    if (stab_err != 0) begin
      bad++; $display("FAIL happy_stable: reg/data moved %0d times mid-transfer, want 0", stab_err);
    end
  endtask

  task automatic test_start_hold();
    int wrong = 0;
    set_scenario(-1, 0, -1, 7, 0);
    run_sequence(-1);
    total++;
    if (obs_q.size() != 6) begin
      bad++; $display("FAIL hold_count: got %0d start requests, want 6", obs_q.size());
    end
    foreach (hi_q[i]) if (hi_q[i] != 8) wrong++;
    total++;
    if (wrong != 0 || hi_q.size() != 6) begin
      bad++; $display("FAIL hold_len: %0d of %0d starts not held 8 samples, want 0 of 6", wrong, hi_q.size());
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL hold_done: got %b, want 1", done);
    end
  endtask

  task automatic test_retry_success();
    set_scenario(2, 2, -1, 0, 0);
    build_expect();
    run_sequence(-1);
    total++;
    if (pair_diffs() != 0) begin
      bad++; $display("FAIL retry_writes: got %0d writes (%0d diffs), want %0d", obs_q.size(), pair_diffs(), exp_q.size());
    end
    total++;
    if ({done, error} !== 2'b10) begin
      bad++; $display("FAIL retry_status: done/error=%b, want 10", {done, error});
    end
  endtask

  task automatic test_retry_exhaust();
    int last_seen = 0;
    set_scenario(4, 99, -1, 0, 0);
    build_expect();
    run_sequence(-1);
    foreach (obs_q[i]) if (obs_q[i] == 16'h0002) last_seen++;
    total++;
    if (pair_diffs() != 0) begin
      bad++; $display("FAIL exhaust_writes: got %0d writes (%0d diffs), want %0d", obs_q.size(), pair_diffs(), exp_q.size());
    end
    total++;
    if ({done, error, fail_index} !== {2'b01, 4'd4}) begin
      bad++; $display("FAIL exhaust_status: done/error/fail_index=%b/%b/%0d, want 0/1/4", done, error, fail_index);
    end
    total++;
    if (last_seen != 0) begin
      bad++; $display("FAIL exhaust_entry5: got %0d writes of entry 5, want 0", last_seen);
    end
  endtask

  task automatic test_timeout();
    set_scenario(-1, 0, 0, 0, 0);
    build_expect();
    run_sequence(-1);
    total++;
    if (pair_diffs() != 0 || obs_q.size() != 4) begin
      bad++; $display("FAIL timeout_writes: got %0d attempts (%0d diffs), want 4", obs_q.size(), pair_diffs());
    end
    total++;
    if (hi_diffs() != 0) begin
      bad++; $display("FAIL timeout_start_len: %0d start-length diffs, want each %0d samples", hi_diffs(), TMO);
    end
    total++;
    if ({done, error, fail_index} !== {2'b01, 4'd0}) begin
      bad++; $display("FAIL timeout_status: done/error/fail_index=%b/%b/%0d, want 0/1/0", done, error, fail_index);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen = 0;
    set_scenario(-1, 0, -1, 0, 20);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (m_phase == 2 && cur_ent == 3 && !i2c_start) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL midrun_reach: entry 3 transfer not observed within 5000 cycles, want it");
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({i2c_start, i2c_reg_addr, i2c_data, seq_busy, done, error, fail_index} !== 24'h0) begin
      bad++; $display("FAIL midrun_reset: got %h, want 000000",
                      {i2c_start, i2c_reg_addr, i2c_data, seq_busy, done, error, fail_index});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    build_expect();
    run_sequence(2);
    total++;
    if (pair_diffs() != 0) begin
      bad++; $display("FAIL restart_writes: got %0d writes (%0d diffs), want %0d", obs_q.size(), pair_diffs(), exp_q.size());
    end
    total++;
    if ({done, error, seq_busy} !== 3'b100) begin
      bad++; $display("FAIL restart_status: done/error/seq_busy=%b, want 100", {done, error, seq_busy});
    end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 4; it++) begin
      foreach (nack_plan[i]) begin
        r = int'($urandom_range(0, 9));
        nack_plan[i] = (r < 6) ? 0 : (r < 9) ? r - 5 : 9;
      end
      hang_ent    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      fixed_delay = 0;
      fixed_len   = 0;
      build_expect();
      run_sequence(-1);
      total++;
      if (pair_diffs() != 0) begin
        bad++; $display("FAIL rand%0d_writes: got %0d writes (%0d diffs), want %0d", it, obs_q.size(), pair_diffs(), exp_q.size());
      end
      total++;
      if (hi_diffs() != 0) begin
        bad++; $display("FAIL rand%0d_start_len: %0d start-length diffs, want 0", it, hi_diffs());
      end
      total++;
      if ({done, error} !== {exp_done, exp_err}) begin
        bad++; $display("FAIL rand%0d_status: done/error=%b%b, want %b%b", it, done, error, exp_done, exp_err);
      end
      if (exp_err) begin
        total++;
        if (fail_index !== exp_fi) begin
          bad++; $display("FAIL rand%0d_fail_index: got %0d, want %0d", it, fail_index, exp_fi);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0;
    set_scenario(-1, 0, -1, 0, 0);
    test_reset();
    test_happy_path();
    test_start_hold();
    test_retry_success();
    test_retry_exhaust();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
